// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the configurable serial pattern detector.
//   state_e          : detector FSM states
//   DEFAULT_MAX_LEN  : default maximum pattern length in bits
//   DEFAULT_CNT_W    : default width of the saturating match counter
// ----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        DETECT = 2'd2
    } state_e;

    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   in  : clock, rising edge
//   rst_n in  : asynchronous active-low reset, clears the count
//   inc   in  : add one this cycle (ignored once saturated)
//   clr   in  : synchronous clear, wins over inc
//   count out : current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// ----------------------------------------------------------------------------
// seq_detector_param
// Serial pattern detector with a run-time loadable pattern of 1..MAX_LEN bits,
// optional overlapping matches and a saturating match counter.
//   clk          in  : clock, rising edge
//   rst_n        in  : asynchronous active-low reset
//   in_valid     in  : in_bit is accepted this cycle
//   in_bit       in  : serial data bit
//   cfg_load     in  : strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  in  : pattern, bit cfg_len-1 is received first, bit 0 last
//   cfg_len      in  : pattern length
//   cfg_overlap  in  : 1 = overlapping matches, 0 = restart after a match
//   clr_count    in  : synchronous clear of match_count
//   match        out : one-cycle pulse per detected pattern
//   match_count  out : saturating number of matches
//   cfg_err      out : last cfg_load carried an illegal length
//   armed        out : a legal configuration is loaded
// ----------------------------------------------------------------------------
module seq_detector_param
    import seq_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    state_e             state_d,   state_q;
    logic [MAX_LEN-1:0] hist_d,    hist_q;
    logic [LEN_W-1:0]   fill_d,    fill_q;
    logic [MAX_LEN-1:0] pattern_d, pattern_q;
    logic [LEN_W-1:0]   len_d,     len_q;
    logic               overlap_d, overlap_q;
    logic               cfg_err_d, cfg_err_q;
    logic               match_d,   match_q;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               cfg_legal;
    logic               window_hit;

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    assign fill_inc   = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : len_q;
    assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign window_hit = (((hist_shift ^ pattern_q) & len_mask) == '0);

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        cfg_err_d = cfg_err_q;
        match_d   = 1'b0;

        if (cfg_load) begin
            // A load restarts the history; the bit offered alongside it is dropped.
            hist_d = '0;
            fill_d = '0;
            if (cfg_legal) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                cfg_err_d = 1'b0;
                state_d   = FILL;
            end else begin
                cfg_err_d = 1'b1;
                state_d   = IDLE;
            end
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                end
                FILL, DETECT: begin
                    hist_d = hist_shift;
                    fill_d = fill_inc;
                    if (fill_inc == len_q) begin
                        state_d = DETECT;
                        if (window_hit) begin
                            match_d = 1'b1;
                            if (!overlap_q) begin
                                hist_d  = '0;
                                fill_d  = '0;
                                state_d = FILL;
                            end
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register; any unencoded value falls back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_d)
                IDLE, FILL, DETECT: state_q <= state_d;
                default:            state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            cfg_err_q <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            cfg_err_q <= cfg_err_d;
            match_q   <= match_d;
        end
    end

    // The count advances on the same edge that raises the match pulse.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match_d),
        .clr   (clr_count),
        .count (match_count)
    );

    assign match   = match_q;
    assign cfg_err = cfg_err_q;
    assign armed   = (state_q != IDLE);

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, 8, maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W, 8, width of the match counter.
REQ-003 Parameter LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; never overridden).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_bit is accepted this cycle.
REQ-007 in_bit  input  1  serial data bit.
REQ-008 cfg_load  input  1  single-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap.
REQ-009 cfg_pattern  input  MAX_LEN  target pattern; bit cfg_len-1 is the first received bit, bit 0 the last.
REQ-010 cfg_len  input  LEN_W  pattern length.
REQ-011 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
REQ-012 clr_count  input  1  synchronous clear of match_count.
REQ-013 match  output  1  registered one-cycle pulse per detected pattern.
REQ-014 match_count  output  CNT_W  saturating count of matches.
REQ-015 cfg_err  output  1  last cfg_load held an illegal length.
REQ-016 armed  output  1  a legal configuration is loaded (state FILL or DETECT).

Function
REQ-017 The FSM SHALL have exactly three states: IDLE (no legal configuration), FILL (fewer than len bits accepted since the last restart) and DETECT.
REQ-018 On cfg_load with 1 <= cfg_len <= MAX_LEN, the block SHALL latch the configuration, clear the history and fill count, clear cfg_err and enter FILL.
REQ-019 On cfg_load with cfg_len == 0 or cfg_len > MAX_LEN, the block SHALL set cfg_err, enter IDLE and leave match_count unchanged.
REQ-020 cfg_load SHALL take priority over in_valid in the same cycle; that bit is discarded.
REQ-021 In IDLE, accepted bits SHALL be ignored and match SHALL stay 0.
REQ-022 Each accepted bit SHALL shift into the history register LSB-first (newest bit = bit 0).
REQ-023 The fill count SHALL increment on each accepted bit, saturating at len.
REQ-024 FILL SHALL move to DETECT when the fill count reaches len.
REQ-025 A match occurs when an accepted bit makes the fill count equal len and history[len-1:0] == pattern[len-1:0]; bits above len-1 SHALL be ignored.
REQ-026 match SHALL assert exactly one clock after the rising edge that accepts the completing bit, for one cycle.
REQ-027 When a match occurs with overlap = 1, the block SHALL remain in DETECT and keep the history.
REQ-028 When a match occurs with overlap = 0, the block SHALL clear the history and fill count and return to FILL.
REQ-029 On every match, match_count SHALL increment by 1 and saturate at 2^CNT_W-1 without wrapping.
REQ-030 clr_count SHALL zero match_count; a match in the same cycle is not counted (clear wins).
REQ-031 If in_valid = 0, history, fill count and state SHALL hold.
REQ-032 With len = 1, every accepted bit equal to pattern[0] SHALL produce a match, in both overlap modes.

Reset
REQ-033 On rst_n low, the block SHALL immediately set state IDLE, history 0, fill count 0, match 0, match_count 0, cfg_err 0, armed 0 and the latched configuration to 0, whatever the current operation.
REQ-034 After rst_n deasserts, the block SHALL ignore in_valid until a legal cfg_load.

Structure
REQ-035 The shared package seq_pkg SHALL hold the state enum (IDLE, FILL, DETECT) and the default MAX_LEN and CNT_W constants.
REQ-036 The block SHALL use one sub-module, sat_counter (parameter width, inc and clr inputs, saturation), for match_count.
REQ-037 Next-state logic SHALL be a single combinational block with a default assignment, and the state register SHALL have a default branch that recovers to IDLE.

Verification
REQ-038 Load pattern 4'b1001, len 4, overlap 1; stream 1,0,0,1,0,0,1 -> match pulses after bits 4 and 7; match_count = 2.
REQ-039 Same stream with overlap 0 -> match after bit 4 only; match_count = 1.
REQ-040 CNT_W = 2, len 1, pattern 1; five accepted 1s -> five match pulses; match_count stops at 3.
REQ-041 cfg_load with cfg_len = 0, then 9 with MAX_LEN = 8 -> cfg_err = 1, armed = 0, no match on any stream.
REQ-042 Assert rst_n low after bits 1,0,0 of pattern 1001 -> all outputs 0 at once; a later bit 1 gives no match until a new cfg_load.
REQ-043 clr_count together with a completing bit -> match pulses and match_count = 0 next cycle; cfg_load together with in_valid -> that bit is dropped and fill count = 0.
